// File: rtl/history_pkg.sv
`default_nettype none
// ============================================================================
// history_pkg : shared types and default answers for the history reader
// Rev 1.0
// ============================================================================
package history_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_e;

    localparam logic [7:0] DFLT_HALF = 8'd13;
    localparam logic [7:0] DFLT_PREV = 8'd17;

    // Answer returned while the history is still empty.
    function automatic logic [7:0] dflt_value(input logic mode);
        return mode ? DFLT_PREV : DFLT_HALF;
    endfunction

endpackage : history_pkg
`default_nettype wire

// File: rtl/history_ram.sv
`default_nettype none
// ============================================================================
// history_ram : 2^AW x DW history store, 1W + 1 sync R, read-before-write
// Rev 1.0
// ============================================================================
module history_ram #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Both accesses sample the array before this edge's write lands,
    // so a same-cycle collision returns the old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : history_ram
`default_nettype wire

// File: rtl/history_reader.sv
`default_nettype none
// ============================================================================
// history_reader : look-back reads (half-index / previous) of a circular history
// Rev 1.0
// ============================================================================
module history_reader
    import history_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_req_i,
    input  logic          rd_mode_i,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [DW-1:0] rd_data_o,
    output logic          busy_o,
    output logic          full_o,
    output logic          err_o
);

    localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] ONE   = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;

    state_e        state_q;
    logic          mode_q;
    logic [AW-1:0] tgt_q;
    logic [AW-1:0] tgt_d;
    logic          dflt_q;
    logic          rd_valid_q;
    logic          busy_q;
    logic          use_ram_q;
    logic [DW-1:0] rd_data_q;
    logic          err_q;
    logic [DW-1:0] ram_rdata;

    // ------------------------------------------------------------------
    // Write side: pointer wraps, count saturates at the depth.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + ONE;
            if (count_q != DEPTH) begin
                count_d = count_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign tgt_d = rd_mode_i ? (wr_ptr_q - ONE) : (wr_ptr_q >> 1);

    history_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .re_i    (state_q == FETCH),
        .raddr_i (tgt_q),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read FSM. The RAM output register only moves in FETCH, so selecting
    // it directly keeps rd_data stable across later writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            tgt_q      <= '0;
            dflt_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            use_ram_q  <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req_i) begin
                        mode_q  <= rd_mode_i;
                        tgt_q   <= tgt_d;
                        dflt_q  <= (count_q == '0);
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    rd_valid_q <= 1'b1;
                    use_ram_q  <= !dflt_q;
                    if (dflt_q) begin
                        rd_data_q <= DW'(dflt_value(mode_q));
                    end
                    state_q <= VALID;
                end
                VALID: begin
                    if (rd_ready_i) begin
                        rd_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (!dflt_q && !rd_data_o[0]) begin
                            err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rd_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data_o  = use_ram_q ? ram_rdata : rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = busy_q;
    assign full_o     = (count_q == DEPTH);
    assign err_o      = err_q;

`ifdef FORMAL
    // Odd-counter invariant seen from the consumer side, for BMC runs.
    always_comb begin : g_err_invariant
        assert (!err_q);
    end
`endif

endmodule : history_reader
`default_nettype wire

// File: tb/tb_history_reader.sv
`default_nettype none
// ============================================================================
// tb_history_reader : directed self-checking bench for history_reader
// Rev 1.0
// ============================================================================
module tb_history_reader;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_req;
    logic       rd_mode;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       busy;
    logic       full;
    logic       err;

    int n_cmp;
    int n_fail;
    int hs_cnt;

    history_reader #(.AW(5), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_req_i   (rd_req),
        .rd_mode_i  (rd_mode),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .busy_o     (busy),
        .full_o     (full),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_valid && rd_ready) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        step();
        wr_en   = 1'b0;
    endtask

    // Request, wait (bounded) for rd_valid, then accept with a zero-wait consumer.
    task automatic read_txn(input logic m, output logic [7:0] d, output int lat);
        rd_req  = 1'b1;
        rd_mode = m;
        step();
        rd_req = 1'b0;
        lat    = 1;
        while (!rd_valid && lat < 10) begin
            step();
            lat++;
        end
        d        = rd_data;
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_empty();
        logic [7:0] d;
        int lat;
        step();
        read_txn(1'b0, d, lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL empty_lat_m0: got %0d want 2", lat); end
        n_cmp++; if (d !== 8'd13) begin n_fail++; $display("FAIL empty_data_m0: got %0d want 13", d); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_idle_busy: got %b want 0", busy); end
        read_txn(1'b1, d, lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL empty_lat_m1: got %0d want 2", lat); end
        n_cmp++; if (d !== 8'd17) begin n_fail++; $display("FAIL empty_data_m1: got %0d want 17", d); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL empty_err: got %b want 0", err); end
    endtask

    task automatic test_lookback();
        logic [7:0] d;
        int lat;
        for (int i = 0; i < 5; i++) do_write(8'(2 * i + 1));
        read_txn(1'b0, d, lat);
        n_cmp++; if (d !== 8'd5) begin n_fail++; $display("FAIL lookback_m0: got %0d want 5", d); end
        read_txn(1'b1, d, lat);
        n_cmp++; if (d !== 8'd9) begin n_fail++; $display("FAIL lookback_m1: got %0d want 9", d); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL lookback_full: got %b want 0", full); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL lookback_err: got %b want 0", err); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        int lat;
        apply_reset();
        for (int i = 0; i < 33; i++) begin
            do_write(8'(2 * i + 1));
            if (i == 30) begin
                n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full_31: got %b want 0", full); end
            end
            if (i == 31) begin
                n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full_32: got %b want 1", full); end
            end
        end
        read_txn(1'b1, d, lat);
        n_cmp++; if (d !== 8'd65) begin n_fail++; $display("FAIL wrap_m1: got %0d want 65", d); end
        read_txn(1'b0, d, lat);
        n_cmp++; if (d !== 8'd65) begin n_fail++; $display("FAIL wrap_m0: got %0d want 65", d); end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full: got %b want 1", full); end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        int lat;
        int hs0;
        // wr_ptr 1 -> 0 so that a mode-0 target equals the FETCH write address
        for (int i = 0; i < 31; i++) do_write(8'd7);
        hs0     = hs_cnt;
        rd_req  = 1'b1;
        rd_mode = 1'b0;
        step();
        rd_req  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'd99;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_fetch_busy: got %b want 1", busy); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_fetch_valid: got %b want 0", rd_valid); end
        step();
        for (int k = 0; k < 5; k++) begin
            rd_req  = (k % 2 == 0);
            wr_data = 8'd11;
            n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, rd_valid); end
            n_cmp++; if (rd_data !== 8'd65) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %0d want 65", k, rd_data); end
            step();
        end
        rd_req   = 1'b0;
        wr_en    = 1'b0;
        n_cmp++; if (rd_data !== 8'd65) begin n_fail++; $display("FAIL bp_final_data: got %0d want 65", rd_data); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_queue_valid: got %b want 0", rd_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_queue_busy: got %b want 0", busy); end
        n_cmp++; if (hs_cnt - hs0 !== 1) begin n_fail++; $display("FAIL bp_handshakes: got %0d want 1", hs_cnt - hs0); end
        // wr_ptr is now 6: addr 1..5 hold 11
        read_txn(1'b1, d, lat);
        n_cmp++; if (d !== 8'd11) begin n_fail++; $display("FAIL bp_after_m1: got %0d want 11", d); end
        read_txn(1'b0, d, lat);
        n_cmp++; if (d !== 8'd11) begin n_fail++; $display("FAIL bp_after_m0: got %0d want 11", d); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b want 0", err); end
    endtask

    task automatic test_invariant();
        logic [7:0] d;
        int lat;
        do_write(8'd4);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL inv_err_before: got %b want 0", err); end
        read_txn(1'b1, d, lat);
        n_cmp++; if (d !== 8'd4) begin n_fail++; $display("FAIL inv_data: got %0d want 4", d); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL inv_err_set: got %b want 1", err); end
        step();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL inv_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        int lat;
        int hs0;
        hs0     = hs_cnt;
        rd_req  = 1'b1;
        rd_mode = 1'b0;
        step();
        rd_req = 1'b0;
        step();
        n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_pre: got %b want 1", rd_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_drop: got %b want 0", rd_valid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err_clear: got %b want 0", err); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_full_clear: got %b want 0", full); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_clear: got %b want 0", busy); end
        n_cmp++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL mid_data_clear: got %0d want 0", rd_data); end
        step();
        rst_n = 1'b1;
        n_cmp++; if (hs_cnt - hs0 !== 0) begin n_fail++; $display("FAIL mid_no_handshake: got %0d want 0", hs_cnt - hs0); end
        read_txn(1'b0, d, lat);
        n_cmp++; if (d !== 8'd13) begin n_fail++; $display("FAIL mid_next_m0: got %0d want 13", d); end
        read_txn(1'b1, d, lat);
        n_cmp++; if (d !== 8'd17) begin n_fail++; $display("FAIL mid_next_m1: got %0d want 17", d); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_next_err: got %b want 0", err); end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        hs_cnt   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'd0;
        rd_req   = 1'b0;
        rd_mode  = 1'b0;
        rd_ready = 1'b0;

        test_reset();
        test_empty();
        test_lookback();
        test_wrap();
        test_backpressure();
        test_invariant();
        test_reset_mid_read();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_history_reader
`default_nettype wire

// File: doc/history_reader.md
# history_reader

Read-side companion for the accumulator history memory in the BMC test designs. A producer streams one 8-bit value per write into a 32-entry circular history. This block serves look-back read requests against that history through a valid/ready handshake: either the half-index entry (`wr_ptr>>1`) or the previous entry (`wr_ptr-1`). It also flags any even value read back, so BMC can check the odd-counter invariant from the consumer side.

## Interface
- `AW`, 5, address width; history depth is 2^AW.
- `DW`, 8, data width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `wr_en`  in  1  write strobe; writes `wr_data` at `wr_ptr`.
- `wr_data`  in  DW  value to store.
- `rd_req`  in  1  read request; sampled only in IDLE.
- `rd_mode`  in  1  0 = half-index entry, 1 = previous entry.
- `rd_valid`  out  1  read result available.
- `rd_ready`  in  1  consumer accepts result.
- `rd_data`  out  DW  read result; stable while `rd_valid && !rd_ready`.
- `busy`  out  1  high in FETCH and VALID.
- `full`  out  1  `count == 2^AW`.
- `err`  out  1  sticky; an even value was delivered from memory.

## Operation
- Write side:
  - `wr_en`: `mem[wr_ptr] <= wr_data`, and `wr_ptr` increments mod 2^AW (31 wraps to 0).
  - `count` increments and saturates at 2^AW.
  - Writes are accepted in every FSM state.
- FSM states:
  - IDLE: on `rd_req`, latch `rd_mode`, `tgt`, and `dflt = (count==0)`, then go to FETCH.
    - Target: `tgt = rd_mode ? wr_ptr-1 (mod 2^AW) : wr_ptr>>1`, computed from the pre-write `wr_ptr` of the request cycle.
  - FETCH: the RAM reads `tgt`. At the next edge, `rd_data` is loaded with the RAM output, or with 13 (mode 0) / 17 (mode 1) when `dflt` is set. Go to VALID.
  - VALID: `rd_valid=1`. On `rd_ready`, go to IDLE.
- `rd_req` outside IDLE is ignored and is not queued.
- Data visibility:
  - A write in the request cycle is visible to the FETCH read.
  - A write to `tgt` during FETCH is not visible; FETCH returns the old data (read-before-write).
  - Writes during VALID do not alter the held `rd_data`.
- `err`: set at the accepting edge (`rd_valid && rd_ready`) if `!dflt && rd_data[0]==0`. Cleared only by reset.
- Reset values:
  - `wr_ptr=0`, `count=0`, state IDLE.
  - `rd_valid=0`, `rd_data=0`, `busy=0`, `full=0`, `err=0`.
  - Memory array is not reset; `count=0` forces default answers until something is written.
- Reset mid-read: the transaction is dropped, `rd_valid` falls immediately (asynchronously), and no handshake completes.

## Timing
- `rd_req` high in cycle N (IDLE): FETCH in N+1, `rd_valid` high from N+2.
- Zero-wait consumer: IDLE again in N+3. Maximum rate is one read per 3 cycles.
- `busy` is registered and equals (state != IDLE).
- `full` rises in the cycle after the 32nd write.

## Structure
- Package `history_pkg`:
  - state enum {IDLE, FETCH, VALID};
  - constants `DFLT_HALF=8'd13`, `DFLT_PREV=8'd17`.
- Sub-module `history_ram`: 2^AW x DW, one write port, one synchronous read port, read-before-write. No reset.
- Top: pointers, count, FSM, `err` logic, and an immediate assertion `!err` for BMC.

## Test plan
- Empty read: reset, then `rd_req` with `rd_mode=0` at cycle 2 → `rd_valid` at cycle 4 with `rd_data=13`. Repeat with `rd_mode=1` → 17. `err` stays 0.
- Look-back: write 1,3,5,7,9 (`wr_ptr=5`), then request mode 0 → 5 (`mem[2]`); request mode 1 → 9 (`mem[4]`).
- Wrap: write 33 odd values (the 33rd value, 65, lands at address 0 and `wr_ptr=1`).
  - Mode 1 returns `mem[0]`=65.
  - `full` is 1.
- Backpressure and collision:
  - Hold `rd_ready=0` for 5 cycles while writing 99 to `tgt` during FETCH.
  - `rd_data` keeps the old value throughout.
  - Extra `rd_req` pulses are ignored; exactly one handshake completes.
- Invariant and reset:
  - Write 4, then read mode 1 → `rd_data=4` and `err` latches 1.
  - Assert `rst_n=0` during VALID → `rd_valid`, `err`, and `count` clear immediately, and the next read returns the default.
